// File: rtl/reaction_pkg.sv
// Shared types and constants for the switch response decoder.
package reaction_pkg;

  localparam int unsigned LED_NUM_DEFAULT = 18;

  // Index width for a vector of n entries (at least one bit).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned LED_IDX_W = idx_width(LED_NUM_DEFAULT);

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/switch_debouncer.sv
// Vector-wide 2-flop synchronizer plus tick-based debounce (SWITCH_DEBOUNCE_EN).
// Without the macro, stable follows the synchronizer and tick marks startup.
module switch_debouncer #(
  parameter int unsigned WIDTH           = 18,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             tick
);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef SWITCH_DEBOUNCE_EN
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] sample_q;
  logic [WIDTH-1:0] stable_q;
  logic [WIDTH-1:0] agree;

  assign tick   = (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign agree  = ~(sync2_q ^ sample_q);
  assign stable = stable_q;

  // A bit only moves once two consecutive tick samples match.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      sample_q <= '0;
      stable_q <= '0;
    end else begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
      if (tick) begin
        sample_q <= sync2_q;
        stable_q <= (stable_q & ~agree) | (sync2_q & agree);
      end
    end
  end
`else
  logic [1:0] start_q;

  assign stable = sync2_q;
  // Held high once the synchronizer carries real switch levels.
  assign tick   = start_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_q <= '0;
    end else begin
      start_q <= {start_q[0], 1'b1};
    end
  end

  if (DEBOUNCE_CYCLES == 0) begin : g_zero_period_unused
  end
`endif

endmodule

// File: rtl/switch_response_decoder.sv
// Turns debounced slide-switch changes into one-cycle toggle events scored against a lit LED.
// Debounce is enabled by defining SWITCH_DEBOUNCE_EN.
module switch_response_decoder
  import reaction_pkg::*;
#(
  parameter int unsigned LED_NUM         = LED_NUM_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [LED_NUM-1:0]            switches,
  input  logic                          clear,
  input  logic                          target_valid,
  input  logic [idx_width(LED_NUM)-1:0] target_index,
  output logic                          toggle_valid,
  output logic [idx_width(LED_NUM)-1:0] toggle_index,
  output logic [LED_NUM-1:0]            toggle_mask,
  output logic                          multi_toggle,
  output logic                          hit,
  output logic                          miss
);

  localparam int unsigned IDX_W = idx_width(LED_NUM);

  state_t             state_q, state_d;
  logic [LED_NUM-1:0] stable;
  logic               tick;
  logic [LED_NUM-1:0] baseline_q, baseline_d;
  logic [LED_NUM-1:0] diff;
  logic [IDX_W-1:0]   diff_idx;
  logic               diff_multi;
  logic               diff_hit;
  logic               load_event;

  switch_debouncer #(
    .WIDTH          (LED_NUM),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .reset_n(reset_n),
    .raw    (switches),
    .stable (stable),
    .tick   (tick)
  );

  assign diff       = stable ^ baseline_q;
  assign diff_multi = (diff & (diff - LED_NUM'(1))) != '0;
  assign diff_hit   = target_valid & ~diff_multi & (diff_idx == target_index);

  // Lowest set bit of diff.
  always_comb begin
    diff_idx = '0;
    for (int i = int'(LED_NUM) - 1; i >= 0; i--) begin
      if (diff[i]) diff_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    baseline_d = baseline_q;
    load_event = 1'b0;
    case (state_q)
      INIT: begin
        if (tick || clear) baseline_d = stable;
        if (tick) state_d = IDLE;
      end
      IDLE: begin
        if (clear) begin
          baseline_d = stable;
        end else if (diff != '0) begin
          state_d    = REPORT;
          load_event = 1'b1;
        end
      end
      REPORT: begin
        state_d    = IDLE;
        // Only the reported bits are absorbed; later changes stay pending as new events.
        baseline_d = clear ? stable : (baseline_q ^ toggle_mask);
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= INIT;
      baseline_q   <= '0;
      toggle_valid <= 1'b0;
      toggle_index <= '0;
      toggle_mask  <= '0;
      multi_toggle <= 1'b0;
      hit          <= 1'b0;
      miss         <= 1'b0;
    end else begin
      state_q      <= state_d;
      baseline_q   <= baseline_d;
      toggle_valid <= load_event;
      if (load_event) begin
        toggle_index <= diff_idx;
        toggle_mask  <= diff;
        multi_toggle <= diff_multi;
        hit          <= diff_hit;
        miss         <= ~diff_hit;
      end else begin
        toggle_index <= '0;
        toggle_mask  <= '0;
        multi_toggle <= 1'b0;
        hit          <= 1'b0;
        miss         <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_switch_response_decoder.sv
// Scoreboard bench for switch_response_decoder; follows SWITCH_DEBOUNCE_EN like the RTL.
module tb_switch_response_decoder;
  import reaction_pkg::*;

  localparam int unsigned N = LED_NUM_DEFAULT;
  localparam int unsigned W = LED_IDX_W;
`ifdef SWITCH_DEBOUNCE_EN
  localparam int SETTLE = 30;
`else
  localparam int SETTLE = 10;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic [N-1:0] switches = '0;
  logic         clear = 1'b0;
  logic         target_valid = 1'b0;
  logic [W-1:0] target_index = '0;
  logic         toggle_valid;
  logic [W-1:0] toggle_index;
  logic [N-1:0] toggle_mask;
  logic         multi_toggle, hit, miss;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  typedef struct {
    logic [N-1:0] mask;
    logic [W-1:0] idx;
    logic         multi;
    logic         hit;
    logic         miss;
    int           cyc;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [N-1:0] flip;
    logic         tv;
    logic [W-1:0] ti;
    logic [W-1:0] idx;
    logic         multi;
    logic         hit;
    logic         miss;
  } vec_t;
  vec_t tbl[9];

  switch_response_decoder #(
    .LED_NUM        (N),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .switches    (switches),
    .clear       (clear),
    .target_valid(target_valid),
    .target_index(target_index),
    .toggle_valid(toggle_valid),
    .toggle_index(toggle_index),
    .toggle_mask (toggle_mask),
    .multi_toggle(multi_toggle),
    .hit         (hit),
    .miss        (miss)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [N-1:0] m, input logic [W-1:0] idx, input logic multi,
                          input logic h, input logic ms, input int ecyc);
    exp_t e;
    e.mask = m; e.idx = idx; e.multi = multi; e.hit = h; e.miss = ms; e.cyc = ecyc;
    sb_q.push_back(e);
  endtask

  // Called at a falling edge: flips switches and records the expected event.
  task automatic drive_flip(input logic [N-1:0] m, input logic [W-1:0] idx, input logic multi,
                            input logic h, input logic ms);
    switches = switches ^ m;
`ifdef SWITCH_DEBOUNCE_EN
    push_exp(m, idx, multi, h, ms, -1);
`else
    push_exp(m, idx, multi, h, ms, cyc + 3);
`endif
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tv();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (toggle_valid) break;
    end
    check_eq("wait_strobe", 32'(toggle_valid), 32'd1);
  endtask

  // Scoreboard consumer: every strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && toggle_valid) begin
      if (sb_q.size() == 0) begin
        check_eq("unexpected_event", {{(32-N){1'b0}}, toggle_mask}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("mask", 32'(toggle_mask), 32'(e.mask));
        check_eq("index", 32'(toggle_index), 32'(e.idx));
        check_eq("multi", 32'(multi_toggle), 32'(e.multi));
        check_eq("hit", 32'(hit), 32'(e.hit));
        check_eq("miss", 32'(miss), 32'(e.miss));
        if (e.cyc >= 0) check_eq("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{18'h00020, 1'b0, 5'd0,  5'd5,  1'b0, 1'b0, 1'b1};
    tbl[1] = '{18'h00020, 1'b1, 5'd5,  5'd5,  1'b0, 1'b1, 1'b0};
    tbl[2] = '{18'h00080, 1'b1, 5'd5,  5'd7,  1'b0, 1'b0, 1'b1};
    tbl[3] = '{18'h00204, 1'b0, 5'd0,  5'd2,  1'b1, 1'b0, 1'b1};
    tbl[4] = '{18'h00204, 1'b1, 5'd2,  5'd2,  1'b1, 1'b0, 1'b1};
    tbl[5] = '{18'h20000, 1'b1, 5'd17, 5'd17, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{18'h00001, 1'b1, 5'd0,  5'd0,  1'b0, 1'b1, 1'b0};
    tbl[7] = '{18'h3FFFF, 1'b1, 5'd0,  5'd0,  1'b1, 1'b0, 1'b1};
    tbl[8] = '{18'h3FFFF, 1'b1, 5'd1,  5'd0,  1'b1, 1'b0, 1'b1};

    #1 reset_n = 1'b0;
    settle(3);
    check_eq("rst_valid", 32'(toggle_valid), 32'd0);
    check_eq("rst_mask", 32'(toggle_mask), 32'd0);
    check_eq("rst_index", 32'(toggle_index), 32'd0);
    check_eq("rst_multi", 32'(multi_toggle), 32'd0);
    check_eq("rst_hit", 32'(hit), 32'd0);
    check_eq("rst_miss", 32'(miss), 32'd0);
    reset_n = 1'b1;
    settle(SETTLE);

    // Single, hit/miss, multi and boundary-index toggles
    foreach (tbl[i]) begin
      target_valid = tbl[i].tv;
      target_index = tbl[i].ti;
      @(negedge clk);
      drive_flip(tbl[i].flip, tbl[i].idx, tbl[i].multi, tbl[i].hit, tbl[i].miss);
      settle(SETTLE);
    end

    // Glitching bit 3
    target_valid = 1'b0;
    @(negedge clk);
`ifdef SWITCH_DEBOUNCE_EN
    for (int p = 0; p < 14; p++) begin
      switches[3] = 1'b1;
      @(negedge clk);
      switches[3] = 1'b0;
      settle(2);
    end
`else
    switches[3] = 1'b1;
    push_exp(18'h00008, 5'd3, 1'b0, 1'b0, 1'b1, cyc + 3);
    push_exp(18'h00008, 5'd3, 1'b0, 1'b0, 1'b1, cyc + 5);
    @(negedge clk);
    switches[3] = 1'b0;
`endif
    settle(SETTLE);

    // Clear on the cycle the change appears: absorbed into baseline, no event
    @(negedge clk);
    switches = switches ^ 18'h00010;
`ifdef SWITCH_DEBOUNCE_EN
    clear = 1'b1;
    settle(SETTLE);
    clear = 1'b0;
`else
    settle(2);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
`endif
    settle(SETTLE);
    @(negedge clk);
    drive_flip(18'h00010, 5'd4, 1'b0, 1'b0, 1'b1);
    settle(SETTLE);

    // Clear during the strobe still completes it, with no second strobe
    @(negedge clk);
    drive_flip(18'h00040, 5'd6, 1'b0, 1'b0, 1'b1);
    wait_tv();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    settle(SETTLE);
    @(negedge clk);
    drive_flip(18'h00040, 5'd6, 1'b0, 1'b0, 1'b1);
    settle(SETTLE);

    // Reset during the strobe
    @(negedge clk);
    drive_flip(18'h00100, 5'd8, 1'b0, 1'b0, 1'b1);
    wait_tv();
    #2 reset_n = 1'b0;
    #1;
    check_eq("midrst_valid", 32'(toggle_valid), 32'd0);
    check_eq("midrst_mask", 32'(toggle_mask), 32'd0);
`ifdef SWITCH_DEBOUNCE_EN
    switches = '0;
`endif
    @(negedge clk);
    reset_n = 1'b1;
    settle(2 * SETTLE);

    // Normal operation after reset
    target_valid = 1'b1;
    target_index = 5'd1;
    @(negedge clk);
    drive_flip(18'h00002, 5'd1, 1'b0, 1'b1, 1'b0);
    settle(SETTLE);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_response_decoder.md
SWITCH_RESPONSE_DECODER -- requirements
Module: switch_response_decoder

Interface
REQ-001 SHALL have parameter LED_NUM, default 18: number of switches and LEDs.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: clock cycles between debounce sample ticks (1 ms at 50 MHz).
REQ-003 SHALL have ports clk, input, 1: single system clock, rising-edge.
REQ-004 SHALL have ports reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports switches, input, LED_NUM: raw, asynchronous slide-switch levels.
REQ-006 SHALL have ports clear, input, 1: single-cycle pulse that re-baselines to the current switch levels.
REQ-007 SHALL have ports target_valid, input, 1: a target LED is lit.
REQ-008 SHALL have ports target_index, input, $clog2(LED_NUM): index of the lit LED.
REQ-009 SHALL have ports toggle_valid, output, 1: single-cycle event strobe.
REQ-010 SHALL have ports toggle_index, output, $clog2(LED_NUM): lowest toggled switch index.
REQ-011 SHALL have ports toggle_mask, output, LED_NUM: all switches toggled in the event.
REQ-012 SHALL have ports multi_toggle, hit, miss, output, 1 each: event qualifiers, valid only while toggle_valid=1.

Function
REQ-013 SHALL pass each switch through a 2-flop synchronizer before any other use.
REQ-014 SHALL generate a sample tick every DEBOUNCE_CYCLES cycles using a free-running counter that wraps from DEBOUNCE_CYCLES-1 to 0.
REQ-015 SHALL update a switch's stable level only when two consecutive tick samples of that switch agree.
REQ-016 SHALL hold a baseline register; diff = stable XOR baseline.
REQ-017 SHALL implement FSM states INIT, IDLE and REPORT.
REQ-018 SHALL transition INIT to IDLE on the first tick, loading baseline from stable on that transition.
REQ-019 SHALL transition IDLE to REPORT when diff is nonzero and clear=0, registering toggle_mask=diff.
REQ-020 SHALL transition REPORT to IDLE unconditionally after one cycle, loading baseline with the registered toggle_mask applied.
REQ-021 SHALL assert toggle_valid only in REPORT, so each event produces exactly one cycle of toggle_valid.
REQ-022 SHALL drive toggle_index as the lowest set bit of toggle_mask.
REQ-023 SHALL assert multi_toggle when toggle_mask has more than one bit set.
REQ-024 SHALL assert hit = target_valid & !multi_toggle & (toggle_index == target_index).
REQ-025 SHALL assert miss = toggle_valid & !hit.
REQ-026 SHALL, when clear=1 in any state, load baseline from stable and suppress any event that cycle.
REQ-027 SHALL, when clear=1 in REPORT, still complete the strobe already in progress.
REQ-028 SHALL include a switch toggling back before the event is reported in that event; once reported, the next opposite change is a new event.
REQ-029 SHALL keep event latency from the stable-level change to toggle_valid at exactly 1 cycle.

Reset
REQ-030 SHALL, while reset_n=0, asynchronously clear the FSM to INIT and zero the synchronizers, tick counter, stable, baseline, toggle_mask and all outputs.
REQ-031 SHALL abandon any pending event on reset mid-operation, with no strobe after release.

Configuration
REQ-032 SHALL, with SWITCH_DEBOUNCE_EN defined, debounce per REQ-014 and REQ-015.
REQ-033 SHALL, without SWITCH_DEBOUNCE_EN, set stable = synchronizer output, remove the tick counter, and have INIT exit 2 cycles after reset release.

Structure
REQ-034 SHALL place the LED_NUM default, the index-width constant and the state enum typedef in shared package reaction_pkg.
REQ-035 SHALL implement synchronization and debounce in sub-module switch_debouncer (vector-wide), instantiated once.

Verification (DEBOUNCE_CYCLES=4)
REQ-036 SHALL cover: switches=0, then flip bit 5 held -> one toggle_valid, index=5, mask=0x00020, multi_toggle=0.
REQ-037 SHALL cover: target_valid=1, target_index=5, flip bit 5 -> hit=1, miss=0; flip bit 7 -> hit=0, miss=1.
REQ-038 SHALL cover: bits 2 and 9 flipped in the same cycle -> one event, mask=0x00204, index=2, multi_toggle=1, miss=1.
REQ-039 SHALL cover: bit 3 glitching 1-cycle pulses every 3 cycles -> no toggle_valid (debounce on); one event per pulse train edge with the macro off.
REQ-040 SHALL cover: flip bit 4 with clear pulsed the cycle diff appears -> no toggle_valid, and baseline bit 4 = 1.
REQ-041 SHALL cover: reset_n low for 1 cycle during REPORT -> toggle_valid drops immediately, FSM INIT, no event after release.
